// File: rtl/alu_result_writeback.sv
// alu_result_writeback: sole path from the 64-bit ALU result to architectural
// state. Loads the Z register pair, commits mul/div results to HI/LO, sources
// mfhi/mflo and hands single-word results to the register file via valid/ready.
module alu_result_writeback #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 4,
  parameter logic [4:0]  OP_MUL         = 5'b01111,
  parameter logic [4:0]  OP_DIV         = 5'b10000,
  parameter logic [4:0]  OP_MFHI        = 5'b11000,
  parameter logic [4:0]  OP_MFLO        = 5'b11001,
  // Value the retired counter returns to while clr is low; zero in normal use.
  parameter logic [15:0] RETIRED_INIT   = 16'h0000
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  opcode,
  input  logic [REG_ADDR_WIDTH-1:0]   dest,
  input  logic [2*DATA_WIDTH-1:0]     C,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [REG_ADDR_WIDTH-1:0]   wb_dest,
  output logic [DATA_WIDTH-1:0]       wb_data,
  output logic [DATA_WIDTH-1:0]       ZHigh,
  output logic [DATA_WIDTH-1:0]       ZLow,
  output logic [DATA_WIDTH-1:0]       HI,
  output logic [DATA_WIDTH-1:0]       LO,
  output logic [15:0]                 retired
);

  // Single-word result opcodes: add..ori form a contiguous range, plus neg/not.
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_ORI = 5'b01110;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_HILO = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  accept;
  logic                  is_hilo;
  logic                  is_mfhi;
  logic                  is_mflo;
  logic                  is_alu;
  logic                  is_wb_op;
  logic                  retire;
  logic [DATA_WIDTH-1:0] wb_data_d;

  function automatic logic is_alu_result(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_ORI)) || (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // in_ready low outside IDLE makes a pending mfhi/mflo wait out the HILO commit.
  assign in_ready = (state_q == ST_IDLE);
  assign wb_valid = (state_q == ST_WB);
  assign accept   = in_valid && in_ready;

  assign is_hilo  = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_mfhi  = (opcode == OP_MFHI);
  assign is_mflo  = (opcode == OP_MFLO);
  assign is_alu   = is_alu_result(opcode);
  assign is_wb_op = is_mfhi || is_mflo || is_alu;

  // An op retires on its HILO commit or on the accepted register-file write.
  assign retire   = (state_q == ST_HILO) || ((state_q == ST_WB) && wb_ready);

  // Select the word handed to the register file at accept time.
  always_comb begin
    wb_data_d = C[DATA_WIDTH-1:0];
    if (is_mfhi) begin
      wb_data_d = HI;
    end else if (is_mflo) begin
      wb_data_d = LO;
    end
  end

  // Next-state logic; non-result opcodes are consumed without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_hilo) begin
            state_d = ST_HILO;
          end else if (is_wb_op) begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_HILO: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; clr drops any pending write-back or HI/LO commit at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Z, write-back, HI/LO and retired-count registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ZHigh   <= '0;
      ZLow    <= '0;
      HI      <= '0;
      LO      <= '0;
      wb_dest <= '0;
      wb_data <= '0;
      retired <= RETIRED_INIT;
    end else begin
      if (accept && (is_hilo || is_wb_op)) begin
        ZHigh <= C[2*DATA_WIDTH-1:DATA_WIDTH];
        ZLow  <= C[DATA_WIDTH-1:0];
      end
      if (accept && is_wb_op) begin
        wb_dest <= dest;
        wb_data <= wb_data_d;
      end
      // HI/LO are committed from Z one cycle after the mul/div accept.
      if (state_q == ST_HILO) begin
        HI <= ZHigh;
        LO <= ZLow;
      end
      if (retire) begin
        retired <= retired + 16'd1;
      end
    end
  end

endmodule
